// File: rtl/array_ctrl_if.sv
// Host/PE-side signal bundle for the array_ctrl instruction sequencer.
// master = host + PE array side, slave = array_ctrl.
interface array_ctrl_if #(
    parameter int SIZE = 4
);
    logic            start;
    logic [31:0]     instruction;
    logic            instr_valid;
    logic            instr_ready;
    logic [SIZE-1:0] pe_done;
    logic [SIZE-1:0] pe_en;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic            issue;
    logic            busy;
    logic            done;
    logic            error;
    logic [7:0]      instr_count;

    modport master (
        output start, instruction, instr_valid, pe_done,
        input  instr_ready, pe_en, opcode, rs, rt, rd, issue, busy, done, error, instr_count
    );

    modport slave (
        input  start, instruction, instr_valid, pe_done,
        output instr_ready, pe_en, opcode, rs, rt, rd, issue, busy, done, error, instr_count
    );
endinterface

// File: rtl/array_ctrl.sv
// Instruction sequencer: queues instructions and broadcasts them to masked PE lanes.
// Optional WAIT-state watchdog is built when ARRAY_CTRL_WATCHDOG_EN is defined.
module array_ctrl #(
    parameter int SIZE   = 4,
    parameter int LENGTH = 4
`ifdef ARRAY_CTRL_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic       clk,
    input  logic       reset,
    array_ctrl_if.slave bus
);
    localparam int AW = $clog2(LENGTH);
    // Queue entries keep only the fields the sequencer uses: opcode/rs/rt/rd plus lane mask.
    localparam int EW = 21 + SIZE;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_e;

    logic [EW-1:0]   mem_q [LENGTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            push_s, pop_s, full_s, empty_s;
    logic [EW-1:0]   head_s;
    logic [5:0]      head_op_s;
    logic [SIZE-1:0] head_mask_s;

    state_e          state_q, state_d;
    logic [SIZE-1:0] pe_en_q, pe_en_d;
    logic [5:0]      opcode_q, opcode_d;
    logic [4:0]      rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic            issue_q, issue_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [7:0]      count_q, count_d;
`ifdef ARRAY_CTRL_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]  wd_q, wd_d;
`endif

    assign full_s          = (cnt_q == (AW+1)'(LENGTH));
    assign empty_s         = (cnt_q == {(AW+1){1'b0}});
    assign push_s          = bus.instr_valid && !full_s;
    assign head_s          = mem_q[rd_ptr_q];
    assign head_op_s       = head_s[SIZE+15 +: 6];
    assign head_mask_s     = (head_s[SIZE-1:0] == {SIZE{1'b0}}) ? {SIZE{1'b1}} : head_s[SIZE-1:0];

    assign bus.instr_ready = !full_s;
    assign bus.pe_en       = pe_en_q;
    assign bus.opcode      = opcode_q;
    assign bus.rs          = rs_q;
    assign bus.rt          = rt_q;
    assign bus.rd          = rd_q;
    assign bus.issue       = issue_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.instr_count = count_q;

    // Queue pointer and occupancy update; pop is only requested when non-empty.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Queue storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.instruction[31:11], bus.instruction[SIZE-1:0]};
        end
    end

    // Sequencer next-state and registered output values.
    always_comb begin
        state_d  = state_q;
        pop_s    = 1'b0;
        pe_en_d  = pe_en_q;
        opcode_d = opcode_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        count_d  = count_q;
        error_d  = error_q;
`ifdef ARRAY_CTRL_WATCHDOG_EN
        wd_d     = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    count_d = 8'd0;
                    error_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (empty_s) begin
                    state_d = S_DONE;
                end else begin
                    pop_s = 1'b1;
                    if (head_op_s == 6'h00) begin
                        state_d = S_FETCH;
                    end else if (head_op_s == 6'h3F) begin
                        state_d = S_DONE;
                    end else begin
                        opcode_d = head_op_s;
                        rs_d     = head_s[SIZE+10 +: 5];
                        rt_d     = head_s[SIZE+5 +: 5];
                        rd_d     = head_s[SIZE +: 5];
                        pe_en_d  = head_mask_s;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
`ifdef ARRAY_CTRL_WATCHDOG_EN
                wd_d    = {WDW{1'b0}};
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if ((bus.pe_done & pe_en_q) == pe_en_q) begin
                    count_d = count_q + 8'd1;
                    pe_en_d = {SIZE{1'b0}};
                    state_d = S_FETCH;
`ifdef ARRAY_CTRL_WATCHDOG_EN
                end else if (wd_q == WDW'(TIMEOUT)) begin
                    error_d = 1'b1;
                    pe_en_d = {SIZE{1'b0}};
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Strobes follow the state they announce by one edge.
        issue_d = (state_q == S_ISSUE);
        done_d  = (state_q == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    // State, queue pointers and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {(AW+1){1'b0}};
            pe_en_q  <= {SIZE{1'b0}};
            opcode_q <= 6'd0;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            issue_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            pe_en_q  <= pe_en_d;
            opcode_q <= opcode_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            issue_q  <= issue_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

`ifdef ARRAY_CTRL_WATCHDOG_EN
    // WAIT-state watchdog counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= {WDW{1'b0}};
        end else begin
            wd_q <= wd_d;
        end
    end
`endif
endmodule

// File: tb/tb_array_ctrl.sv
// Directed self-checking bench for array_ctrl (SIZE=4, LENGTH=4).
// Watchdog scenario is selected by ARRAY_CTRL_WATCHDOG_EN.
module tb_array_ctrl;
    localparam int SIZE = 4;
    localparam int TO   = 255;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    array_ctrl_if #(.SIZE(SIZE)) bus ();
    array_ctrl #(.SIZE(SIZE), .LENGTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        bus.instruction = w;
        bus.instr_valid = 1'b1;
        tick(1);
        bus.instr_valid = 1'b0;
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        push(32'h08241800);
        push(32'h0C000000);
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL ready_two: got %b want 1", bus.instr_ready); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
        checks++;
        if ({bus.pe_en, bus.opcode, bus.rs, bus.rt, bus.rd, bus.issue, bus.busy, bus.done, bus.error, bus.instr_count} !== 37'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0",
                {bus.pe_en, bus.opcode, bus.rs, bus.rt, bus.rd, bus.issue, bus.busy, bus.done, bus.error, bus.instr_count});
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        pulse_start;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b want 1", bus.busy); end
        tick(1);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL empty_done_early: got %b want 0", bus.done); end
        tick(1);
        checks++; if ({bus.done, bus.issue, bus.instr_count} !== {1'b1, 1'b0, 8'd0}) begin
            errors++; $display("FAIL empty_done: got done=%b issue=%b cnt=%0d want 1 0 0", bus.done, bus.issue, bus.instr_count);
        end
        tick(1);
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL empty_after: got %b want 00", {bus.done, bus.busy}); end
    endtask

    task automatic test_basic;
        bus.pe_done = 4'hF;
        push(32'h08241800);
        pulse_start;
        tick(2);
        checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL basic_issue: got %b want 1", bus.issue); end
        checks++; if ({bus.opcode, bus.rs, bus.rt, bus.rd} !== {6'd2, 5'd1, 5'd4, 5'd3}) begin
            errors++; $display("FAIL basic_fields: got op=%0d rs=%0d rt=%0d rd=%0d want 2 1 4 3", bus.opcode, bus.rs, bus.rt, bus.rd);
        end
        checks++; if (bus.pe_en !== 4'hF) begin errors++; $display("FAIL basic_pe_en: got %h want f", bus.pe_en); end
        tick(1);
        checks++; if ({bus.issue, bus.instr_count} !== {1'b0, 8'd1}) begin
            errors++; $display("FAIL basic_retire: got issue=%b cnt=%0d want 0 1", bus.issue, bus.instr_count);
        end
        tick(2);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", bus.done); end
    endtask

    task automatic test_mask;
        bus.pe_done = 4'b0000;
        push({6'd5, 5'd0, 5'd0, 5'd0, 11'h005});
        pulse_start;
        tick(2);
        checks++; if ({bus.issue, bus.pe_en} !== {1'b1, 4'b0101}) begin
            errors++; $display("FAIL mask_issue: got issue=%b pe_en=%b want 1 0101", bus.issue, bus.pe_en);
        end
        bus.pe_done = 4'b1001;
        tick(4);
        checks++; if ({bus.busy, bus.pe_en, bus.instr_count} !== {1'b1, 4'b0101, 8'd0}) begin
            errors++; $display("FAIL mask_hold: got busy=%b pe_en=%b cnt=%0d want 1 0101 0", bus.busy, bus.pe_en, bus.instr_count);
        end
        bus.pe_done = 4'b1101;
        tick(1);
        checks++; if ({bus.pe_en, bus.instr_count} !== {4'b0000, 8'd1}) begin
            errors++; $display("FAIL mask_exit: got pe_en=%b cnt=%0d want 0000 1", bus.pe_en, bus.instr_count);
        end
        tick(2);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mask_done: got %b want 1", bus.done); end
        bus.pe_done = 4'b0000;
    endtask

    task automatic test_program;
        int n_iss = 0;
        int done_at = 0;
        bus.pe_done = 4'hF;
        push(32'h00000000);
        push(32'h08000000);
        push(32'hFC000000);
        push(32'h0C000000);
        bus.start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 1) bus.start = 1'b0;
            if (bus.issue === 1'b1) n_iss++;
            if (i == 4) begin
                checks++; if ({bus.issue, bus.opcode} !== {1'b1, 6'd2}) begin
                    errors++; $display("FAIL prog_issue: got issue=%b op=%0d want 1 2", bus.issue, bus.opcode);
                end
            end
            if (bus.done === 1'b1 && done_at == 0) done_at = i;
        end
        checks++; if (n_iss !== 1) begin errors++; $display("FAIL prog_n_issue: got %0d want 1", n_iss); end
        checks++; if (done_at !== 7) begin errors++; $display("FAIL prog_done_cycle: got %0d want 7", done_at); end
        checks++; if (bus.instr_count !== 8'd1) begin errors++; $display("FAIL prog_count: got %0d want 1", bus.instr_count); end
        pulse_start;
        tick(2);
        checks++; if ({bus.issue, bus.opcode} !== {1'b1, 6'd3}) begin
            errors++; $display("FAIL prog_second: got issue=%b op=%0d want 1 3", bus.issue, bus.opcode);
        end
        tick(3);
        checks++; if ({bus.done, bus.instr_count} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL prog_second_done: got done=%b cnt=%0d want 1 1", bus.done, bus.instr_count);
        end
    endtask

    task automatic test_back_to_back;
        int         iss_cyc [8];
        logic [5:0] iss_op  [8];
        int         n_iss = 0;
        int         i = 2;
        logic       seen_done = 1'b0;
        bus.pe_done = 4'hF;
        push(32'h04000000);
        push(32'h08000000);
        push(32'h0C000000);
        push(32'h10000000);
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.instr_ready); end
        push(32'h54000000);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL full_prepop: got %b want 0", bus.instr_ready); end
        bus.instruction = 32'h58000000;
        bus.instr_valid = 1'b1;
        tick(1);
        bus.instr_valid = 1'b0;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL full_postpop: got %b want 1", bus.instr_ready); end
        while (!seen_done && i < 40) begin
            tick(1);
            i++;
            if (bus.issue === 1'b1 && n_iss < 8) begin
                iss_cyc[n_iss] = i;
                iss_op[n_iss]  = bus.opcode;
                n_iss++;
            end
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got no done want done"); end
        checks++; if (n_iss !== 4) begin errors++; $display("FAIL b2b_n_issue: got %0d want 4", n_iss); end
        for (int j = 0; j < 4 && j < n_iss; j++) begin
            checks++; if (iss_op[j] !== 6'(j + 1) || iss_cyc[j] !== 3 + 3 * j) begin
                errors++; $display("FAIL b2b_issue%0d: got op=%0d cyc=%0d want op=%0d cyc=%0d", j, iss_op[j], iss_cyc[j], j + 1, 3 + 3 * j);
            end
        end
        checks++; if (bus.instr_count !== 8'd4) begin errors++; $display("FAIL b2b_count: got %0d want 4", bus.instr_count); end
        pulse_start;
        tick(2);
        checks++; if ({bus.done, bus.issue} !== 2'b10) begin
            errors++; $display("FAIL full_dropped: got done=%b issue=%b want 1 0", bus.done, bus.issue);
        end
    endtask

    task automatic test_reset_wait;
        bus.pe_done = 4'h0;
        push(32'h1C000000);
        pulse_start;
        tick(6);
        checks++; if ({bus.busy, bus.pe_en} !== {1'b1, 4'hF}) begin
            errors++; $display("FAIL rw_waiting: got busy=%b pe_en=%h want 1 f", bus.busy, bus.pe_en);
        end
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.pe_en, bus.instr_count} !== {1'b0, 4'h0, 8'd0}) begin
            errors++; $display("FAIL rw_abandon: got busy=%b pe_en=%h cnt=%0d want 0 0 0", bus.busy, bus.pe_en, bus.instr_count);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1);
    endtask

`ifdef ARRAY_CTRL_WATCHDOG_EN
    task automatic test_watchdog;
        int   done_at = 0;
        logic err_pre = 1'b1;
        logic err_at  = 1'b0;
        bus.pe_done = 4'h0;
        push(32'h1C000000);
        bus.start = 1'b1;
        for (int i = 1; i <= TO + 20; i++) begin
            tick(1);
            if (i == 1) bus.start = 1'b0;
            if (i == TO + 3) err_pre = bus.error;
            if (i == TO + 4) err_at = bus.error;
            if (bus.done === 1'b1 && done_at == 0) begin
                done_at = i;
                checks++; if ({bus.instr_count, bus.pe_en} !== {8'd0, 4'h0}) begin
                    errors++; $display("FAIL wd_state: got cnt=%0d pe_en=%h want 0 0", bus.instr_count, bus.pe_en);
                end
            end
        end
        checks++; if (err_pre !== 1'b0) begin errors++; $display("FAIL wd_early: got %b want 0", err_pre); end
        checks++; if (err_at !== 1'b1) begin errors++; $display("FAIL wd_error: got %b want 1", err_at); end
        checks++; if (done_at !== TO + 5) begin errors++; $display("FAIL wd_done_cycle: got %0d want %0d", done_at, TO + 5); end
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", bus.error); end
        pulse_start;
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b want 0", bus.error); end
        tick(3);
    endtask
`else
    task automatic test_watchdog;
        bus.pe_done = 4'h0;
        push(32'h1C000000);
        pulse_start;
        tick(300);
        checks++; if ({bus.busy, bus.error, bus.pe_en, bus.instr_count} !== {1'b1, 1'b0, 4'hF, 8'd0}) begin
            errors++; $display("FAIL nowd_wait: got busy=%b err=%b pe_en=%h cnt=%0d want 1 0 f 0",
                bus.busy, bus.error, bus.pe_en, bus.instr_count);
        end
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(1);
    endtask
`endif

    initial begin
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instruction = 32'd0;
        bus.pe_done     = 4'h0;
        tick(2);
        reset = 1'b1;
        tick(1);
        test_reset;
        test_basic;
        test_mask;
        test_program;
        test_back_to_back;
        test_reset_wait;
        test_watchdog;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/array_ctrl.md
# array_ctrl

Instruction sequencer for the SIZE-PE array processor. Buffers 32-bit instructions in a LENGTH-deep queue, and on `start` pops them one at a time. For each instruction it broadcasts opcode and register fields to the PEs selected by a lane mask, then waits until every selected PE reports completion. Sits between the host/test interface and the PE array inside `Top`, replacing direct instruction drive.

## Interface
- `SIZE`, 4, number of PEs; must be 1..11
- `LENGTH`, 4, instruction queue depth; power of two, ≥2
- `TIMEOUT`, 255, watchdog limit in cycles for the WAIT state (used only with the macro)

- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  level/pulse; sampled only in IDLE
- `instruction`  in  32  `[31:26]` opcode, `[25:21]` rs, `[20:16]` rt, `[15:11]` rd, `[10:0]` funct (PE mask in `[SIZE-1:0]`)
- `instr_valid`  in  1  push request
- `instr_ready`  out  1  queue not full
- `pe_done`  in  SIZE  per-PE completion level
- `pe_en`  out  SIZE  lanes selected for the current instruction
- `opcode`  out  6  broadcast opcode
- `rs`, `rt`, `rd`  out  5 each  broadcast register fields
- `issue`  out  1  one-cycle strobe; broadcast fields valid
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle program-complete pulse
- `error`  out  1  sticky watchdog error
- `instr_count`  out  8  instructions retired since the last `start`

## Operation
- Queue push: `instr_valid & instr_ready` writes `instruction` into the tail. Pushes are accepted in every state. `instr_ready` = !full. A push while full is dropped, with no state change.
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE: `start`=1 → FETCH. This also clears `instr_count` and `error`.
- FETCH, queue empty: → DONE.
- FETCH, opcode 6'h00 (NOP): pop; stay in FETCH. Does not increment `instr_count`.
- FETCH, opcode 6'h3F (HALT): pop → DONE.
- FETCH, any other opcode: pop, latch fields → ISSUE.
  - Mask = `funct[SIZE-1:0]`. A mask of 0 means all lanes.
- ISSUE: `issue`=1 for exactly one cycle, with `pe_en`/`opcode`/`rs`/`rt`/`rd` driven → WAIT.
- WAIT: `opcode`/`rs`/`rt`/`rd`/`pe_en` hold their values.
  - When `(pe_done & pe_en) == pe_en`: `instr_count`+1 (wraps 255→0), `pe_en` clears → FETCH.
  - `pe_done` bits of unselected lanes are ignored.
- DONE: `done`=1 for one cycle → IDLE. Queue contents not yet popped remain for the next `start`.
- `start` outside IDLE is ignored.

## Timing
- All outputs are registered except `instr_ready` (combinational from the queue count).
- Reset (`reset`=0, async) clears:
  - state to IDLE and the queue to empty
  - `pe_en`, `opcode`, `rs`, `rt`, `rd`, `issue`, `busy`, `done`, `error`, `instr_count` to 0
  - `instr_ready` to 1 (returns 1 immediately)
- Reset asserted mid-WAIT abandons the instruction; nothing is retired.
- Cycle latency:
  - `start` sampled at edge k → FETCH from k+1 → `issue` high from edge k+2.
  - If `pe_done` already satisfies the mask during the issue cycle, WAIT exits after one cycle. Next `issue` is no sooner than 3 cycles after the previous one.
- Each NOP costs one FETCH cycle. HALT or an empty queue → `done` asserted two edges after the fetch edge.
- Push and pop in the same cycle: count unchanged. A push into a full queue during a pop cycle is still rejected, because `instr_ready` reflects the pre-pop count.
- Pointers wrap modulo LENGTH.

## Configuration
- `ARRAY_CTRL_WATCHDOG_EN` defined:
  - A WAIT cycle counter resets on entry.
  - Reaching TIMEOUT cycles sets `error`=1 (sticky until the next `start` or reset), clears `pe_en`, and goes to DONE.
  - The instruction is not counted. Remaining queue entries are kept.
- Not defined: no counter is built, `error` is tied to 0, and WAIT waits indefinitely.

## Test plan
- Reset: push 2 instructions, assert `reset`=0 → queue empty, `instr_ready`=1, all outputs 0. Then `start` with an empty queue → `done` pulse 2 cycles later, `instr_count`=0.
- Push 32'h08241800, `pe_done` tied 4'hF, `start` → `issue` at k+2 with `opcode`=2, `rs`=1, `rt`=4, `rd`=3, `pe_en`=4'hF. `instr_count`=1, then `done`.
- Mask funct=11'h005, `pe_done` raises lanes 0 and 2 only after 5 cycles, lane 1 stays 0 → WAIT exits exactly when lane 2 rises, with `pe_en`=4'b0101.
- Queue NOP, OP 6'h02, HALT, OP 6'h03 → one `issue`, `done` after HALT, `instr_count`=1. The second `start` issues opcode 3.
- Fill LENGTH=4 → `instr_ready`=0 and a fifth push is dropped. Push during a FETCH pop while full → still rejected; count = 3 afterwards.
- With `ARRAY_CTRL_WATCHDOG_EN` and `pe_done`=0 → `error`=1 and `done` after TIMEOUT+1 WAIT cycles, `instr_count`=0. The next `start` clears `error`.
